prf_sequencer: RTL
==================

// Module: prf_sequencer
// PURPOSE
//  Pulse-repetition sequencer for the beam-scanner Doppler front end. Drives the burst clock
//  generator's frequency strobe and select lines (F8/F4/F2, WR_Freq) and its BURST_EN, ADC_EN and
//  SMPL_EN enables, one transmit/receive line per PRF period. Config comes from the host-side
//  register write path. Shadowed config is applied only at line boundaries.
// PARAMETERS
//  PER_W  16  width of PRF period, gate delay and gate length (CLK64 cycles)
//  BC_W   6   width of burst cycle count
//  LN_W   12  width of line count / line counter
// PORTS
//  CLK64      in   1      64 MHz system clock
//  RES        in   1      asynchronous reset, active-high
//  CFG_WR     in   1      1-cycle strobe: latch CFG_* into shadow registers
//  CFG_FREQ   in   2      01=8 MHz, 10=4 MHz, 11=2 MHz, 00=invalid
//  CFG_BCYC   in   BC_W   burst length in carrier cycles (0 = no transmit)
//  CFG_PER    in   PER_W  PRF period in CLK64 cycles, counted from burst start
//  CFG_GDLY   in   PER_W  gate delay, burst start -> SMPL_EN rise
//  CFG_GLEN   in   PER_W  gate length (SMPL_EN high cycles)
//  CFG_NLINE  in   LN_W   lines per run, 0 = continuous
//  START      in   1      1-cycle run request
//  STOP       in   1      1-cycle stop request
//  F8,F4,F2   out  1      one-hot frequency select to clock generator
//  WR_Freq    out  1      frequency latch strobe (generator samples on rising edge)
//  BURST_EN   out  1      transmit burst enable
//  ADC_EN     out  1      ADC clock enable, covers burst through gate end
//  SMPL_EN    out  1      range-gate sample enable
//  LINE_DONE  out  1      1-cycle pulse at end of each PRF period
//  LINE_CNT   out  LN_W   lines completed in current run
//  BUSY       out  1      high in any state other than IDLE
//  OVR        out  1      sticky: gate truncated by period end; cleared on START
// BEHAVIOUR
//  - RES: every output and counter 0, state IDLE, shadow cleared (freq 00). RES mid-line drops
//    all enables in the same cycle.
//  - CFG_WR accepted in every state; writes shadow only. Active config <= shadow on leaving
//    IDLE and at each line boundary.
//  - START in IDLE with shadow freq != 00 -> FREQ. Otherwise ignored (also ignored when BUSY).
//    START and STOP in the same cycle: STOP wins.
//  - FREQ (3 cycles): c0 drive F lines from active freq, WR_Freq=0; c1 WR_Freq=1; c2 WR_Freq=0
//    -> BURST. Entered at a line boundary only if the newly applied freq differs from the
//    current F lines; the 3 cycles lengthen that line.
//  - Period counter P resets to 0 on BURST entry and increments every CLK64.
//  - Burst length TB = BCYC * {8,16,32} cycles for 8/4/2 MHz.
//  - BURST: BURST_EN=1 and ADC_EN=1 while P < TB.
//  - RX: ADC_EN=1 until P = GDLY+GLEN. SMPL_EN=1 for GDLY <= P < GDLY+GLEN.
//  - HOLD: all enables 0 until P = PER-1.
//  - At P = PER-1: LINE_DONE=1 and LINE_CNT+1. Next line BURST (or FREQ) follows with no gap.
//  - If any window reaches PER: truncate it at PER-1 and set OVR. BCYC=0 skips transmit.
//  - PER=0 is treated as 1.
//  - Run end: line count reached (NLINE != 0) or a pending STOP -> IDLE after LINE_DONE.
//    STOP is held pending until that boundary. The current line always completes.
//  - LINE_CNT holds in IDLE; it clears on START and saturates at all-ones when NLINE=0.
//  - Outputs are registered: window edges appear 1 cycle after the P compare.
// TESTING
//  - Reset and shadow: RES mid-BURST -> BURST_EN/ADC_EN/SMPL_EN/BUSY = 0 next edge, F lines 0.
//    START with freq 00 -> BUSY stays 0.
//  - Single line: freq=01, BCYC=4, PER=200, GDLY=60, GLEN=20, NLINE=1, START.
//    Expect: WR_Freq high 1 cycle with F8=1; BURST_EN 32 cycles; SMPL_EN cycles 60-79 after
//    burst start; LINE_DONE at P=199; BUSY falls; LINE_CNT=1.
//  - Freq change: CFG_WR freq=11 mid line 2 of a continuous run -> FREQ inserted after LINE_DONE,
//    F2=1, next BURST_EN 32*BCYC cycles, that line is PER+3 cycles.
//  - Truncation: PER=100, GDLY=90, GLEN=20 -> SMPL_EN high P=90-99 only, OVR=1 and sticky.
//    Next START clears OVR.
//  - STOP/START collision: STOP mid-line -> line finishes, LINE_DONE, IDLE.
//    STOP+START together in IDLE -> remains IDLE.

Source files
------------

// File: rtl/prf_sequencer_if.sv
// Host/config and clock-generator signal bundle for the PRF sequencer.
// The host side (master) drives config and run control; the sequencer (slave) drives the generator lines.
interface prf_sequencer_if #(
  parameter int unsigned PER_W = 16,
  parameter int unsigned BC_W  = 6,
  parameter int unsigned LN_W  = 12
);
  logic             CFG_WR;
  logic [1:0]       CFG_FREQ;
  logic [BC_W-1:0]  CFG_BCYC;
  logic [PER_W-1:0] CFG_PER;
  logic [PER_W-1:0] CFG_GDLY;
  logic [PER_W-1:0] CFG_GLEN;
  logic [LN_W-1:0]  CFG_NLINE;
  logic             START;
  logic             STOP;
  logic             F8;
  logic             F4;
  logic             F2;
  logic             WR_Freq;
  logic             BURST_EN;
  logic             ADC_EN;
  logic             SMPL_EN;
  logic             LINE_DONE;
  logic [LN_W-1:0]  LINE_CNT;
  logic             BUSY;
  logic             OVR;

  modport master (
    output CFG_WR, CFG_FREQ, CFG_BCYC, CFG_PER, CFG_GDLY, CFG_GLEN, CFG_NLINE, START, STOP,
    input  F8, F4, F2, WR_Freq, BURST_EN, ADC_EN, SMPL_EN, LINE_DONE, LINE_CNT, BUSY, OVR
  );

  modport slave (
    input  CFG_WR, CFG_FREQ, CFG_BCYC, CFG_PER, CFG_GDLY, CFG_GLEN, CFG_NLINE, START, STOP,
    output F8, F4, F2, WR_Freq, BURST_EN, ADC_EN, SMPL_EN, LINE_DONE, LINE_CNT, BUSY, OVR
  );
endinterface

// File: rtl/prf_sequencer.sv
// Pulse-repetition sequencer: one transmit/receive line per PRF period, with burst-clock
// frequency programming inserted at line boundaries when the applied frequency changes.
module prf_sequencer #(
  parameter int unsigned PER_W = 16,
  parameter int unsigned BC_W  = 6,
  parameter int unsigned LN_W  = 12
) (
  input logic            CLK64,
  input logic            RES,
  prf_sequencer_if.slave bus
);
  localparam int unsigned TB_W = BC_W + 5;
  localparam int unsigned EW   = ((PER_W > TB_W) ? PER_W : TB_W) + 1;

  typedef enum logic [1:0] {IDLE, FREQ, LINE} state_t;

  state_t           state;
  logic [1:0]       fcnt;
  logic [PER_W-1:0] pcnt;
  logic             stop_pend;

  logic [1:0]       s_freq, a_freq;
  logic [BC_W-1:0]  s_bcyc, a_bcyc;
  logic [PER_W-1:0] s_per, a_per;
  logic [PER_W-1:0] s_gdly, a_gdly;
  logic [PER_W-1:0] s_glen, a_glen;
  logic [LN_W-1:0]  s_nline, a_nline;

  logic [2:0]       f_sel;
  logic             wr_freq;
  logic             burst_en;
  logic             adc_en;
  logic             smpl_en;
  logic             line_done;
  logic [LN_W-1:0]  line_cnt;
  logic             busy;
  logic             ovr;

  logic [EW-1:0]    tb_len, per_eff, p_ext, g_start, g_end;
  logic             last, burst_c, adc_c, smpl_c, trunc, run_end, go_freq;
  logic [1:0]       nxt_freq;
  logic [LN_W-1:0]  cnt_inc;

  function automatic logic [2:0] freq_oh(input logic [1:0] f);
    unique case (f)
      2'b01:   freq_oh = 3'b100;
      2'b10:   freq_oh = 3'b010;
      2'b11:   freq_oh = 3'b001;
      default: freq_oh = 3'b000;
    endcase
  endfunction

  // Window compares against the running period counter, all from the active config
  always_comb begin
    tb_len = '0;
    unique case (a_freq)
      2'b01:   tb_len = EW'({a_bcyc, 3'b000});
      2'b10:   tb_len = EW'({a_bcyc, 4'b0000});
      2'b11:   tb_len = EW'({a_bcyc, 5'b00000});
      default: tb_len = '0;
    endcase
    per_eff  = (a_per == '0) ? EW'(1) : EW'(a_per);
    p_ext    = EW'(pcnt);
    g_start  = EW'(a_gdly);
    g_end    = EW'(a_gdly) + EW'(a_glen);
    last     = (p_ext == per_eff - EW'(1));
    burst_c  = (p_ext < tb_len);
    smpl_c   = (p_ext >= g_start) && (p_ext < g_end);
    adc_c    = burst_c || (p_ext < g_end);
    trunc    = (tb_len > per_eff) || ((a_glen != '0) && (g_end > per_eff));
    cnt_inc  = (line_cnt == '1) ? line_cnt : line_cnt + LN_W'(1);
    run_end  = stop_pend || bus.STOP || ((a_nline != '0) && (cnt_inc == a_nline));
    // An invalid shadowed frequency keeps the generator on its current setting
    nxt_freq = (s_freq != 2'b00) ? s_freq : a_freq;
    go_freq  = (freq_oh(nxt_freq) != f_sel);
  end

  always_ff @(posedge CLK64 or posedge RES) begin
    if (RES) begin
      state     <= IDLE;
      fcnt      <= '0;
      pcnt      <= '0;
      stop_pend <= 1'b0;
      s_freq    <= '0;
      s_bcyc    <= '0;
      s_per     <= '0;
      s_gdly    <= '0;
      s_glen    <= '0;
      s_nline   <= '0;
      a_freq    <= '0;
      a_bcyc    <= '0;
      a_per     <= '0;
      a_gdly    <= '0;
      a_glen    <= '0;
      a_nline   <= '0;
      f_sel     <= '0;
      wr_freq   <= 1'b0;
      burst_en  <= 1'b0;
      adc_en    <= 1'b0;
      smpl_en   <= 1'b0;
      line_done <= 1'b0;
      line_cnt  <= '0;
      busy      <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      wr_freq   <= 1'b0;
      burst_en  <= 1'b0;
      adc_en    <= 1'b0;
      smpl_en   <= 1'b0;
      line_done <= 1'b0;

      if (bus.CFG_WR) begin
        s_freq  <= bus.CFG_FREQ;
        s_bcyc  <= bus.CFG_BCYC;
        s_per   <= bus.CFG_PER;
        s_gdly  <= bus.CFG_GDLY;
        s_glen  <= bus.CFG_GLEN;
        s_nline <= bus.CFG_NLINE;
      end

      if ((state != IDLE) && bus.STOP) stop_pend <= 1'b1;

      unique case (state)
        IDLE: begin
          if (bus.START && !bus.STOP && (s_freq != 2'b00)) begin
            a_freq    <= s_freq;
            a_bcyc    <= s_bcyc;
            a_per     <= s_per;
            a_gdly    <= s_gdly;
            a_glen    <= s_glen;
            a_nline   <= s_nline;
            line_cnt  <= '0;
            ovr       <= 1'b0;
            stop_pend <= 1'b0;
            fcnt      <= '0;
            busy      <= 1'b1;
            state     <= FREQ;
          end
        end

        // c0 sets the select lines, c1 raises the latch strobe, c2 drops it
        FREQ: begin
          f_sel   <= freq_oh(a_freq);
          wr_freq <= (fcnt == 2'd1);
          fcnt    <= fcnt + 2'd1;
          if (fcnt == 2'd2) begin
            fcnt  <= '0;
            pcnt  <= '0;
            state <= LINE;
          end
        end

        LINE: begin
          burst_en <= burst_c;
          adc_en   <= adc_c;
          smpl_en  <= smpl_c;
          if (trunc) ovr <= 1'b1;
          pcnt <= pcnt + PER_W'(1);
          if (last) begin
            line_done <= 1'b1;
            line_cnt  <= cnt_inc;
            pcnt      <= '0;
            a_freq    <= nxt_freq;
            a_bcyc    <= s_bcyc;
            a_per     <= s_per;
            a_gdly    <= s_gdly;
            a_glen    <= s_glen;
            a_nline   <= s_nline;
            if (run_end) begin
              busy      <= 1'b0;
              stop_pend <= 1'b0;
              state     <= IDLE;
            end else if (go_freq) begin
              fcnt  <= '0;
              state <= FREQ;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.F8        = f_sel[2];
  assign bus.F4        = f_sel[1];
  assign bus.F2        = f_sel[0];
  assign bus.WR_Freq   = wr_freq;
  assign bus.BURST_EN  = burst_en;
  assign bus.ADC_EN    = adc_en;
  assign bus.SMPL_EN   = smpl_en;
  assign bus.LINE_DONE = line_done;
  assign bus.LINE_CNT  = line_cnt;
  assign bus.BUSY      = busy;
  assign bus.OVR       = ovr;
endmodule
